// File: rtl/kw11l_pkg.sv
// Shared definitions for the KW11-L line clock.
// Holds the CSR address and default vector, the CSR bit positions, the default
// tick divider, the CSR and vector-handshake types, and the CSR read formatter.
package kw11l_pkg;

    localparam logic [15:0] CSR_ADDR        = 16'o177546;
    localparam logic [15:0] DEFAULT_VECTOR  = 16'o000100;
    localparam int          CSR_MON         = 32'd7;
    localparam int          CSR_IE          = 32'd6;
    localparam int unsigned DEFAULT_CLK_DIV = 32'd2000000;

    // Only the two implemented CSR bits are stored.
    typedef struct packed {
        logic mon;
        logic ie;
    } csr_t;

    typedef enum logic [0:0] {
        VEC_IDLE = 1'b0,
        VEC_ACK  = 1'b1
    } vec_state_t;

    // Place the stored bits at their CSR positions; all other bits read 0.
    function automatic logic [15:0] csr_word(input csr_t csr);
        logic [15:0] word;
        word          = 16'h0000;
        word[CSR_MON] = csr.mon;
        word[CSR_IE]  = csr.ie;
        return word;
    endfunction

endpackage

// File: rtl/kw11l_debounce.sv
// Front-panel on/off button handling for the line clock.
// Ports:
//   clk, rst    - bus clock and synchronous active-high reset
//   tick        - one-cycle line-clock pulse; the debouncer only advances on it
//   button      - raw asynchronous button input
//   clk_status  - registered enable state, toggled once per press
module kw11l_debounce (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic button,
    output logic clk_status
);

    logic [1:0] sync_r;
    logic [1:0] shift_r;
    logic       lock_r;
    logic       status_r;
    logic [1:0] shift_next_s;
    logic       lock_next_s;
    logic       status_next_s;

    // Two-flop synchronizer for the asynchronous button.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_r <= 2'b00;
        end else begin
            sync_r <= {sync_r[0], button};
        end
    end

    // Tick-sampled shift; the decision uses the freshly shifted value so a
    // press is recognised on the second tick that sees it.
    always_comb begin
        shift_next_s  = shift_r;
        lock_next_s   = lock_r;
        status_next_s = status_r;
        if (tick) begin
            shift_next_s = {shift_r[0], sync_r[1]};
            if ((shift_next_s == 2'b11) && !lock_r) begin
                status_next_s = ~status_r;
                lock_next_s   = 1'b1;
            end else if (shift_next_s == 2'b00) begin
                lock_next_s = 1'b0;
            end else begin
                lock_next_s = lock_r;
            end
        end else begin
            shift_next_s = shift_r;
        end
    end

    // Debounce state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_r  <= 2'b00;
            lock_r   <= 1'b0;
            status_r <= 1'b0;
        end else begin
            shift_r  <= shift_next_s;
            lock_r   <= lock_next_s;
            status_r <= status_next_s;
        end
    end

    assign clk_status = status_r;

endmodule

// File: rtl/kw11l_line_clock.sv
// KW11-L compatible line-clock peripheral.
// Generates a tick every CLK_DIV bus cycles, holds the CSR (MON bit 7, IE bit 6),
// raises a vectored interrupt on ticks while enabled, and answers the CPU
// vector fetch. A debounced front-panel button turns the clock on and off.
// Ports:
//   wb_clk_i, wb_rst_i      - bus clock, synchronous active-high reset
//   wb_cyc_i .. wb_dat_i    - Wishbone slave inputs (strobe pre-decoded)
//   wb_dat_o, wb_ack_o      - read data (valid with ack), 1-cycle ack pulse
//   irq, istb, iack, ivec   - interrupt request and vector handshake
//   button, clk_status      - on/off button and enable indicator
module kw11l_line_clock
    import kw11l_pkg::*;
#(
    parameter int unsigned CLK_DIV = DEFAULT_CLK_DIV,
    parameter logic [15:0] VECTOR  = DEFAULT_VECTOR
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [1:0]  wb_sel_i,
    input  logic [15:0] wb_dat_i,
    output logic [15:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        irq,
    input  logic        istb,
    output logic        iack,
    output logic [15:0] ivec,
    input  logic        button,
    output logic        clk_status
);

    localparam int unsigned      DIV_W    = (CLK_DIV > 32'd1) ? $clog2(CLK_DIV) : 32'd1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 32'd1);

    logic [DIV_W-1:0] div_r;
    logic             tick_r;
    csr_t             csr_r;
    csr_t             csr_next_s;
    logic             req_r;
    logic             req_next_s;
    logic             req_set_s;
    logic             req_clr_s;
    vec_state_t       vec_state_r;
    vec_state_t       vec_state_next_s;
    logic             vec_grant_s;
    logic             ack_r;
    logic [15:0]      dat_r;
    logic [15:0]      ivec_r;
    logic             clk_status_s;
    logic             bus_req_s;
    logic             wr_s;
    logic             unused_s;

    // Address decode happens upstream, so only the low CSR byte matters here.
    assign unused_s = &{1'b0, CSR_ADDR, wb_dat_i[15:8], wb_dat_i[5:0], wb_sel_i[1], 1'b0};

    // Free-running divider; tick is high the cycle after the last count.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            div_r  <= {DIV_W{1'b0}};
            tick_r <= 1'b0;
        end else begin
            if (div_r == DIV_LAST) begin
                div_r <= {DIV_W{1'b0}};
            end else begin
                div_r <= div_r + DIV_W'(1);
            end
            tick_r <= (div_r == DIV_LAST);
        end
    end

    kw11l_debounce u_debounce (
        .clk        (wb_clk_i),
        .rst        (wb_rst_i),
        .tick       (tick_r),
        .button     (button),
        .clk_status (clk_status_s)
    );

    // A new request is the first cycle of cyc&stb; writes land on that edge.
    assign bus_req_s = wb_cyc_i & wb_stb_i & ~ack_r;
    assign wr_s      = bus_req_s & wb_we_i & wb_sel_i[0];

    // CSR update: a tick setting MON beats a software clear in the same cycle.
    always_comb begin
        csr_next_s = csr_r;
        if (tick_r && clk_status_s) begin
            csr_next_s.mon = 1'b1;
        end else if (wr_s && !wb_dat_i[CSR_MON]) begin
            csr_next_s.mon = 1'b0;
        end else begin
            csr_next_s.mon = csr_r.mon;
        end
        if (wr_s) begin
            csr_next_s.ie = wb_dat_i[CSR_IE];
        end else begin
            csr_next_s.ie = csr_r.ie;
        end
    end

    // Request set uses IE as it was before any same-cycle write; set wins.
    assign req_set_s = tick_r & clk_status_s & csr_r.ie;
    assign req_clr_s = vec_grant_s | (wr_s & ~wb_dat_i[CSR_IE]);

    // Interrupt request next state.
    always_comb begin
        req_next_s = req_r;
        if (req_set_s) begin
            req_next_s = 1'b1;
        end else if (req_clr_s) begin
            req_next_s = 1'b0;
        end else begin
            req_next_s = req_r;
        end
    end

    // Vector handshake: answer istb only while requesting, hold until istb drops.
    always_comb begin
        vec_state_next_s = vec_state_r;
        vec_grant_s      = 1'b0;
        case (vec_state_r)
            VEC_IDLE: begin
                if (istb && req_r) begin
                    vec_state_next_s = VEC_ACK;
                    vec_grant_s      = 1'b1;
                end else begin
                    vec_state_next_s = VEC_IDLE;
                end
            end
            VEC_ACK: begin
                if (!istb) begin
                    vec_state_next_s = VEC_IDLE;
                end else begin
                    vec_state_next_s = VEC_ACK;
                end
            end
            default: begin
                vec_state_next_s = VEC_IDLE;
            end
        endcase
    end

    // Register file, bus response and handshake state.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            csr_r       <= '{mon: 1'b0, ie: 1'b0};
            req_r       <= 1'b0;
            vec_state_r <= VEC_IDLE;
            ivec_r      <= 16'h0000;
            ack_r       <= 1'b0;
            dat_r       <= 16'h0000;
        end else begin
            csr_r       <= csr_next_s;
            req_r       <= req_next_s;
            vec_state_r <= vec_state_next_s;
            ivec_r      <= (vec_state_next_s == VEC_ACK) ? VECTOR : 16'h0000;
            ack_r       <= wb_cyc_i & wb_stb_i & ~ack_r;
            dat_r       <= csr_word(csr_r);
        end
    end

    assign wb_ack_o   = ack_r;
    assign wb_dat_o   = dat_r;
    assign irq        = req_r;
    assign iack       = (vec_state_r == VEC_ACK);
    assign ivec       = ivec_r;
    assign clk_status = clk_status_s;

endmodule

// File: tb/tb_kw11l_line_clock.sv
// Bench for kw11l_line_clock with a short divider: a table of CSR accesses,
// directed sequences for button, tick collisions and handshake, then random
// traffic compared every cycle against a rule-level reference model.
module tb_kw11l_line_clock;

    localparam int unsigned DIV = 10;
    localparam logic [15:0] VEC = 16'o000100;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i = 1'b0;
    logic        wb_cyc_i = 1'b0;
    logic        wb_stb_i = 1'b0;
    logic        wb_we_i  = 1'b0;
    logic [1:0]  wb_sel_i = 2'b00;
    logic [15:0] wb_dat_i = 16'h0000;
    logic [15:0] wb_dat_o;
    logic        wb_ack_o;
    logic        irq;
    logic        istb     = 1'b0;
    logic        iack;
    logic [15:0] ivec;
    logic        button   = 1'b0;
    logic        clk_status;

    int total = 0;
    int bad   = 0;

    kw11l_line_clock #(.CLK_DIV(DIV), .VECTOR(VEC)) dut (
        .wb_clk_i   (wb_clk_i),
        .wb_rst_i   (wb_rst_i),
        .wb_cyc_i   (wb_cyc_i),
        .wb_stb_i   (wb_stb_i),
        .wb_we_i    (wb_we_i),
        .wb_sel_i   (wb_sel_i),
        .wb_dat_i   (wb_dat_i),
        .wb_dat_o   (wb_dat_o),
        .wb_ack_o   (wb_ack_o),
        .irq        (irq),
        .istb       (istb),
        .iack       (iack),
        .ivec       (ivec),
        .button     (button),
        .clk_status (clk_status)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    task automatic check1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %06o want %06o at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: cycle age since reset gives the tick schedule, a short
    // history of button values stands in for the synchronizer delay.
    bit          m_valid = 1'b0;
    bit          m_mon, m_ie, m_req, m_iack, m_ack, m_status, m_lock, m_prev;
    logic [15:0] m_dat;
    int          m_age;
    bit          m_hist[$];

    function automatic bit m_tick_now();
        return m_valid && (m_age > 0) && ((m_age % DIV) == 0);
    endfunction

    task automatic model_advance();
        bit tick, bus_req, wr, sample, set_req, vec, clr_req;
        if (wb_rst_i) begin
            m_valid = 1'b1; m_mon = 1'b0; m_ie = 1'b0; m_req = 1'b0; m_iack = 1'b0;
            m_ack = 1'b0; m_status = 1'b0; m_lock = 1'b0; m_prev = 1'b0;
            m_dat = 16'h0000; m_age = 0; m_hist = '{1'b0, 1'b0};
            return;
        end
        if (!m_valid) return;
        tick    = m_tick_now();
        bus_req = wb_cyc_i && wb_stb_i && !m_ack;
        wr      = bus_req && wb_we_i && wb_sel_i[0];
        sample  = m_hist[m_hist.size() - 2];
        set_req = tick && m_status && m_ie;
        vec     = istb && m_req && !m_iack;
        clr_req = vec || (wr && !wb_dat_i[6]);
        m_dat   = (m_mon ? 16'o000200 : 16'o000000) | (m_ie ? 16'o000100 : 16'o000000);
        if (tick && m_status) m_mon = 1'b1;
        else if (wr && !wb_dat_i[7]) m_mon = 1'b0;
        if (wr) m_ie = wb_dat_i[6];
        if (set_req) m_req = 1'b1;
        else if (clr_req) m_req = 1'b0;
        m_iack = m_iack ? istb : vec;
        m_ack  = bus_req;
        if (tick) begin
            if (m_prev && sample && !m_lock) begin
                m_status = !m_status;
                m_lock   = 1'b1;
            end else if (!m_prev && !sample) begin
                m_lock = 1'b0;
            end
            m_prev = sample;
        end
        m_age++;
        m_hist.push_back(button);
        if (m_hist.size() > 3) void'(m_hist.pop_front());
    endtask

    task automatic model_check();
        if (!m_valid) return;
        check1("m_ack", wb_ack_o, m_ack);
        check1("m_irq", irq, m_req);
        check1("m_iack", iack, m_iack);
        check16("m_ivec", ivec, m_iack ? VEC : 16'h0000);
        check1("m_status", clk_status, m_status);
        if (m_ack) check16("m_rdata", wb_dat_o, m_dat);
    endtask

    // One clock: model consumes this cycle's inputs, DUT sampled 1 after the edge.
    task automatic step();
        model_advance();
        @(posedge wb_clk_i);
        #1;
        model_check();
    endtask

    task automatic wait_tick();
        int n = 0;
        do begin
            step();
            n++;
        end while (!m_tick_now() && n < 3 * DIV);
        check1("tick_wait", m_tick_now(), 1'b1);
    endtask

    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) wait_tick();
    endtask

    task automatic bus_write(input logic [1:0] sel, input logic [15:0] data);
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1; wb_sel_i = sel; wb_dat_i = data;
        step();
        check1("wr_ack_hi", wb_ack_o, 1'b1);
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
        step();
        check1("wr_ack_lo", wb_ack_o, 1'b0);
    endtask

    task automatic bus_read(output logic [15:0] data);
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0;
        step();
        check1("rd_ack_hi", wb_ack_o, 1'b1);
        data = wb_dat_o;
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        step();
        check1("rd_ack_lo", wb_ack_o, 1'b0);
    endtask

    typedef struct {
        logic [1:0]  sel;
        logic [15:0] wdata;
        logic [15:0] exp_read;
    } bus_vec_t;

    initial begin
        bus_vec_t    vecs[6];
        logic [15:0] r;

        vecs[0] = '{sel: 2'b01, wdata: 16'h0040, exp_read: 16'o000100};
        vecs[1] = '{sel: 2'b10, wdata: 16'h0000, exp_read: 16'o000100};
        vecs[2] = '{sel: 2'b11, wdata: 16'hFFFF, exp_read: 16'o000100};
        vecs[3] = '{sel: 2'b01, wdata: 16'hFF80, exp_read: 16'o000000};
        vecs[4] = '{sel: 2'b11, wdata: 16'h00C0, exp_read: 16'o000100};
        vecs[5] = '{sel: 2'b01, wdata: 16'h0000, exp_read: 16'o000000};

        // Reset and idle with the button released.
        wb_rst_i = 1'b1;
        step();
        step();
        wb_rst_i = 1'b0;
        step();
        check1("rst_ack", wb_ack_o, 1'b0);
        check1("rst_irq", irq, 1'b0);
        check1("rst_iack", iack, 1'b0);
        check16("rst_ivec", ivec, 16'h0000);
        check1("rst_status", clk_status, 1'b0);
        for (int i = 0; i < 100; i++) begin
            step();
            check1("idle_irq", irq, 1'b0);
            check1("idle_status", clk_status, 1'b0);
        end
        bus_read(r);
        check16("idle_csr", r, 16'o000000);

        // CSR access table, clock disabled.
        for (int i = 0; i < 6; i++) begin
            bus_write(vecs[i].sel, vecs[i].wdata);
            bus_read(r);
            check16($sformatf("table_%0d", i), r, vecs[i].exp_read);
        end

        // Button: press right at a tick so the next tick is the first sample.
        wait_tick();
        button = 1'b1;
        wait_tick(); step();
        check1("btn_tick1", clk_status, 1'b0);
        wait_tick(); step();
        check1("btn_tick2", clk_status, 1'b1);
        wait_ticks(2); step();
        check1("btn_held", clk_status, 1'b1);
        button = 1'b0;
        wait_ticks(3); step();
        check1("btn_release", clk_status, 1'b1);
        button = 1'b1;
        wait_ticks(3); step();
        check1("btn_repress", clk_status, 1'b0);
        button = 1'b0;
        wait_ticks(3);
        button = 1'b1;
        wait_ticks(3);
        button = 1'b0;
        wait_ticks(3); step();
        check1("btn_on", clk_status, 1'b1);
        check1("btn_irq", irq, 1'b0);

        // MON set by tick and cleared by software.
        wait_tick(); step();
        bus_write(2'b01, 16'o000000);
        bus_read(r);
        check16("mon_clr", r, 16'o000000);
        wait_tick(); step();
        bus_read(r);
        check16("mon_set", r, 16'o000200);
        check1("mon_irq", irq, 1'b0);
        bus_write(2'b01, 16'o000000);
        bus_read(r);
        check16("mon_clr2", r, 16'o000000);

        // Interrupt and vector handshake.
        bus_write(2'b01, 16'o000100);
        check1("ie_irq0", irq, 1'b0);
        wait_tick(); step();
        check1("ie_irq1", irq, 1'b1);
        bus_read(r);
        check16("ie_csr", r, 16'o000300);
        istb = 1'b1;
        step();
        check1("hs_iack", iack, 1'b1);
        check16("hs_ivec", ivec, 16'o000100);
        check1("hs_irq", irq, 1'b0);
        step(); step();
        check1("hs_hold", iack, 1'b1);
        check16("hs_hold_vec", ivec, 16'o000100);
        istb = 1'b0;
        step();
        check1("hs_drop", iack, 1'b0);
        check16("hs_drop_vec", ivec, 16'h0000);

        // Write of 0 in the tick cycle: MON ends 1, IE 0, req set from old IE.
        wait_tick();
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1; wb_sel_i = 2'b01; wb_dat_i = 16'h0000;
        step();
        check1("col_ack", wb_ack_o, 1'b1);
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
        step();
        bus_read(r);
        check16("col_csr", r, 16'o000200);
        check1("col_irq", irq, 1'b1);
        istb = 1'b1;
        step();
        check1("col_iack", iack, 1'b1);
        istb = 1'b0;
        step();

        // Vector acknowledge in the tick cycle: request stays up.
        bus_write(2'b01, 16'o000100);
        wait_tick(); step();
        check1("vt_irq_pre", irq, 1'b1);
        wait_tick();
        istb = 1'b1;
        step();
        check1("vt_iack", iack, 1'b1);
        check1("vt_irq", irq, 1'b1);
        istb = 1'b0;
        step();
        check1("vt_iack_lo", iack, 1'b0);
        check1("vt_irq_kept", irq, 1'b1);

        // High-byte-only write is ignored; reset in the middle of a handshake.
        bus_read(r);
        check16("bs_before", r, 16'o000300);
        bus_write(2'b10, 16'h0000);
        bus_read(r);
        check16("bs_after", r, 16'o000300);
        istb = 1'b1;
        step();
        check1("mr_iack", iack, 1'b1);
        wb_rst_i = 1'b1;
        step();
        check1("mr_iack0", iack, 1'b0);
        check1("mr_irq0", irq, 1'b0);
        check16("mr_ivec0", ivec, 16'h0000);
        check1("mr_status0", clk_status, 1'b0);
        wb_rst_i = 1'b0;
        istb = 1'b0;
        step();
        bus_read(r);
        check16("mr_csr0", r, 16'o000000);

        // Random traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            wb_rst_i = ($urandom_range(0, 599) == 0);
            wb_cyc_i = ($urandom_range(0, 3) == 0);
            wb_stb_i = wb_cyc_i;
            wb_we_i  = ($urandom_range(0, 1) == 1);
            wb_sel_i = 2'($urandom_range(0, 3));
            wb_dat_i = 16'($urandom);
            istb     = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 39) == 0) button = ~button;
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
